// File: rtl/y86_pkg.sv
// Shared Y86 definitions: register IDs, datapath sizes and the W-stage field bundle.
package y86_pkg;
  localparam int DW   = 32;
  localparam int NREG = 8;
  localparam int RW   = 3;

  typedef logic [RW-1:0] reg_id_t;

  localparam reg_id_t REG_EAX = 3'd0;
  localparam reg_id_t REG_ECX = 3'd1;
  localparam reg_id_t REG_EDX = 3'd2;
  localparam reg_id_t REG_EBX = 3'd3;
  localparam reg_id_t REG_ESP = 3'd4;
  localparam reg_id_t REG_EBP = 3'd5;
  localparam reg_id_t REG_ESI = 3'd6;
  localparam reg_id_t REG_EDI = 3'd7;

  typedef struct packed {
    logic          weE;
    reg_id_t       dstE;
    logic [DW-1:0] valE;
    logic          weM;
    reg_id_t       dstM;
    logic [DW-1:0] valM;
  } w_fields_t;
endpackage

// File: rtl/reg_cell.sv
// One architectural register: clear beats the M port, which beats the E port.
module reg_cell #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          weM_i,
  input  logic [DW-1:0] valM_i,
  input  logic          weE_i,
  input  logic [DW-1:0] valE_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)      q_d = RST_VAL;
    else if (weM_i) q_d = valM_i;
    else if (weE_i) q_d = valE_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= RST_VAL;
    else          q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/reg_writeback.sv
// Y86 write-back stage: W pipeline register feeding the eight-entry register bank.
module reg_writeback
  import y86_pkg::*;
#(
  parameter logic [DW-1:0] ESP_INIT = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m_weE,
  input  logic [2:0]    m_dstE,
  input  logic [DW-1:0] m_valE,
  input  logic          m_weM,
  input  logic [2:0]    m_dstM,
  input  logic [DW-1:0] m_valM,
  input  logic          W_stall,
  input  logic          W_bubble,
  input  logic [7:0]    clr,
  output logic          W_weE,
  output logic [2:0]    W_dstE,
  output logic [DW-1:0] W_valE,
  output logic          W_weM,
  output logic [2:0]    W_dstM,
  output logic [DW-1:0] W_valM,
  output logic [DW-1:0] Q_0,
  output logic [DW-1:0] Q_1,
  output logic [DW-1:0] Q_2,
  output logic [DW-1:0] Q_3,
  output logic [DW-1:0] Q_4,
  output logic [DW-1:0] Q_5,
  output logic [DW-1:0] Q_6,
  output logic [DW-1:0] Q_7
);
  w_fields_t w_q, w_d;
  logic [NREG-1:0][DW-1:0] q;

  always_comb begin
    w_d = w_q;
    if (W_stall)       w_d = w_q;
    else if (W_bubble) w_d = '0;
    else               w_d = '{weE: m_weE, dstE: m_dstE, valE: m_valE,
                               weM: m_weM, dstM: m_dstM, valM: m_valM};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) w_q <= '0;
    else          w_q <= w_d;
  end

  // Commits come straight from w_q, so a stalled W re-commits every cycle.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    localparam logic [DW-1:0] RV = (gi == int'(REG_ESP)) ? ESP_INIT : '0;
    reg_cell #(.DW(DW), .RST_VAL(RV)) u_cell (
      .clk    (clk),
      .reset_n(reset_n),
      .clr_i  (clr[gi]),
      .weM_i  (w_q.weM && (w_q.dstM == RW'(gi))),
      .valM_i (w_q.valM),
      .weE_i  (w_q.weE && (w_q.dstE == RW'(gi))),
      .valE_i (w_q.valE),
      .q_o    (q[gi])
    );
  end

  assign W_weE  = w_q.weE;
  assign W_dstE = w_q.dstE;
  assign W_valE = w_q.valE;
  assign W_weM  = w_q.weM;
  assign W_dstM = w_q.dstM;
  assign W_valM = w_q.valM;

  assign Q_0 = q[0];
  assign Q_1 = q[1];
  assign Q_2 = q[2];
  assign Q_3 = q[3];
  assign Q_4 = q[4];
  assign Q_5 = q[5];
  assign Q_6 = q[6];
  assign Q_7 = q[7];
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with hand-computed expectations.
module tb_reg_writeback;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        m_weE, m_weM, W_stall, W_bubble;
  logic [2:0]  m_dstE, m_dstM;
  logic [31:0] m_valE, m_valM;
  logic [7:0]  clr;
  logic        W_weE, W_weM;
  logic [2:0]  W_dstE, W_dstM;
  logic [31:0] W_valE, W_valM;
  logic [31:0] Q_0, Q_1, Q_2, Q_3, Q_4, Q_5, Q_6, Q_7;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] ESP0 = 32'h1000;

  reg_writeback #(.ESP_INIT(ESP0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_weE(m_weE), .m_dstE(m_dstE), .m_valE(m_valE),
    .m_weM(m_weM), .m_dstM(m_dstM), .m_valM(m_valM),
    .W_stall(W_stall), .W_bubble(W_bubble), .clr(clr),
    .W_weE(W_weE), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_weM(W_weM), .W_dstM(W_dstM), .W_valM(W_valM),
    .Q_0(Q_0), .Q_1(Q_1), .Q_2(Q_2), .Q_3(Q_3),
    .Q_4(Q_4), .Q_5(Q_5), .Q_6(Q_6), .Q_7(Q_7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_weE = 0; m_dstE = 0; m_valE = 0;
    m_weM = 0; m_dstM = 0; m_valM = 0;
  endtask

  initial begin
    reset_n = 0; W_stall = 0; W_bubble = 0; clr = 0;
    idle();
    edge1(); edge1();
    chk("rst_q4",  Q_4, ESP0);
    chk("rst_q0",  Q_0, 32'h0);
    chk("rst_q7",  Q_7, 32'h0);
    chk("rst_weE", {31'b0, W_weE}, 32'h0);
    chk("rst_weM", {31'b0, W_weM}, 32'h0);
    reset_n = 1;

    // E write to reg 3: visible on W after edge N, on Q_3 only after N+1
    m_weE = 1; m_dstE = 3'd3; m_valE = 32'hDEADBEEF;
    edge1();
    chk("w_valE",  W_valE, 32'hDEADBEEF);
    chk("w_weE",   {31'b0, W_weE}, 32'h1);
    chk("q3_early", Q_3, 32'h0);
    idle();
    edge1();
    chk("q3_commit", Q_3, 32'hDEADBEEF);
    chk("w_weE_off", {31'b0, W_weE}, 32'h0);

    // collision on reg 4: M wins
    m_weE = 1; m_dstE = 3'd4; m_valE = 32'h11;
    m_weM = 1; m_dstM = 3'd4; m_valM = 32'h22;
    edge1(); idle(); edge1();
    chk("collide_q4", Q_4, 32'h22);

    // distinct destinations commit together
    m_weE = 1; m_dstE = 3'd1; m_valE = 32'h5;
    m_weM = 1; m_dstM = 3'd2; m_valM = 32'h7;
    edge1(); idle(); edge1();
    chk("dual_q1", Q_1, 32'h5);
    chk("dual_q2", Q_2, 32'h7);

    // stall beats bubble; W holds, stalled W still commits
    m_weE = 1; m_dstE = 3'd6; m_valE = 32'hAA;
    edge1();
    W_stall = 1; W_bubble = 1;
    m_weE = 1; m_dstE = 3'd0; m_valE = 32'hBB;
    m_weM = 1; m_dstM = 3'd7; m_valM = 32'hCC;
    edge1();
    chk("stall_valE", W_valE, 32'hAA);
    chk("stall_dstE", {29'b0, W_dstE}, 32'h6);
    chk("stall_weM",  {31'b0, W_weM}, 32'h0);
    chk("stall_q6",   Q_6, 32'hAA);
    W_stall = 0;
    edge1();
    chk("bub_weE",  {31'b0, W_weE}, 32'h0);
    chk("bub_weM",  {31'b0, W_weM}, 32'h0);
    chk("bub_valE", W_valE, 32'h0);
    W_bubble = 0; idle();
    edge1();
    chk("bub_q0", Q_0, 32'h0);
    chk("bub_q7", Q_7, 32'h0);

    // clear beats a write to reg 4; write to reg 5 still lands
    m_weE = 1; m_dstE = 3'd4; m_valE = 32'h55;
    m_weM = 1; m_dstM = 3'd5; m_valM = 32'h66;
    edge1();
    idle(); clr = 8'b0001_0000;
    edge1();
    chk("clr_q4", Q_4, ESP0);
    chk("clr_q5", Q_5, 32'h66);
    clr = 0;

    // async reset between edges drops the pending W write
    m_weE = 1; m_dstE = 3'd2; m_valE = 32'h99;
    edge1();
    idle();
    #2 reset_n = 0;
    #1;
    chk("arst_weE", {31'b0, W_weE}, 32'h0);
    chk("arst_q1",  Q_1, 32'h0);
    chk("arst_q3",  Q_3, 32'h0);
    chk("arst_q4",  Q_4, ESP0);
    edge1();
    reset_n = 1;
    edge1();
    chk("arst_q2", Q_2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
